// File: rtl/vector_engine_pkg.sv
// Shared types and field layout for the descriptor-driven vector add/sub engine.
package vector_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DESC_REQ,
    DESC_CAP,
    RD_A,
    RD_B,
    EXE,
    WR,
    DONE
  } state_t;

  // Config cell (memory cell 0) layout
  localparam int CFG_START   = 0;
  localparam int CFG_A_LSB   = 1;
  localparam int CFG_B_LSB   = 11;
  localparam int CFG_DST_LSB = 21;
  localparam int CFG_OP      = 31;

  // Status cell (memory cell 1) layout
  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_ERROR     = 2;
  localparam int ST_COUNT_LSB = 16;

  // Lane operation select
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Descriptor block: cell 2 holds the block count in its low 16 bits
  localparam int DESC_LEN_CELL = 2;
  localparam int LEN_W         = 16;

  function automatic logic [31:0] status_word(input logic busy,
                                              input logic done,
                                              input logic error,
                                              input logic [LEN_W-1:0] count);
    logic [31:0] w;
    w = '0;
    w[ST_BUSY]                   = busy;
    w[ST_DONE]                   = done;
    w[ST_ERROR]                  = error;
    w[ST_COUNT_LSB +: LEN_W]     = count;
    return w;
  endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// Blocks-wide lane ALU: independent add or subtract per cell, no carry across lanes.
module vector_lane_alu
  import vector_engine_pkg::*;
#(
  parameter int blocks     = 4,
  parameter int cell_width = 32
) (
  input  logic [blocks*cell_width-1:0] a,
  input  logic [blocks*cell_width-1:0] b,
  input  logic                         op,
  output logic [blocks*cell_width-1:0] result
);

  // Each lane wraps modulo 2^cell_width on its own
  always_comb begin
    result = '0;
    for (int i = 0; i < blocks; i++) begin
      case (op)
        OP_ADD:  result[i*cell_width +: cell_width] = a[i*cell_width +: cell_width] + b[i*cell_width +: cell_width];
        OP_SUB:  result[i*cell_width +: cell_width] = a[i*cell_width +: cell_width] - b[i*cell_width +: cell_width];
        default: result[i*cell_width +: cell_width] = '0;
      endcase
    end
  end

endmodule

// File: rtl/vector_engine.sv
// Descriptor-driven element-wise add/sub engine: fetches a descriptor, streams
// operand blocks A and B, writes A op B block by block and reports through status.
module vector_engine
  import vector_engine_pkg::*;
#(
  parameter int size       = 1024,
  parameter int blocks     = 4,
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int width      = blocks * cell_width
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic [cell_width-1:0] in_config,
  input  logic [cell_width-1:0] in_status,
  input  logic [width-1:0]      in_data,
  output logic [log_size-1:0]   out_address,
  output logic [width-1:0]      out_data,
  output logic                  out_read_en,
  output logic                  out_write_en,
  output logic [cell_width-1:0] out_status,
  output logic                  out_write_status_en
);

  // Wide enough that base + len*blocks can never wrap
  localparam int CHK_W = log_size + 17;
  localparam logic [log_size-1:0] STRIDE = log_size'(blocks);

  state_t              state;
  logic [log_size-1:0] a_addr;
  logic [log_size-1:0] b_addr;
  logic [log_size-1:0] dst_addr;
  logic                op;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    k;
  logic [width-1:0]    a_reg;
  logic [width-1:0]    alu_result;

  logic [LEN_W-1:0]    desc_len;
  logic [CHK_W-1:0]    span;
  logic [CHK_W-1:0]    a_end;
  logic [CHK_W-1:0]    b_end;
  logic [CHK_W-1:0]    dst_end;
  logic                desc_error;

  logic                unused_status;
  assign unused_status = ^{in_status[cell_width-1:ST_DONE+1], in_status[ST_DONE-1:0]};

  function automatic logic [cell_width-1:0] status_out(input logic busy,
                                                       input logic done,
                                                       input logic error,
                                                       input logic [LEN_W-1:0] count);
    return cell_width'(status_word(busy, done, error, count));
  endfunction

  // B is taken straight off the read bus in EXE and combined with the captured A
  vector_lane_alu #(
    .blocks     (blocks),
    .cell_width (cell_width)
  ) u_alu (
    .a      (a_reg),
    .b      (in_data),
    .op     (op),
    .result (alu_result)
  );

  // Descriptor range check; dst below cell 2 would clobber config/status
  always_comb begin
    desc_len   = in_data[DESC_LEN_CELL*cell_width +: LEN_W];
    span       = CHK_W'(desc_len) * CHK_W'(blocks);
    a_end      = CHK_W'(a_addr) + span;
    b_end      = CHK_W'(b_addr) + span;
    dst_end    = CHK_W'(dst_addr) + span;
    desc_error = (a_end > CHK_W'(size)) || (b_end > CHK_W'(size)) ||
                 (dst_end > CHK_W'(size)) || (dst_addr < log_size'(2));
  end

  // Control FSM; all memory strobes and status words are registered here
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state               <= IDLE;
      a_addr              <= '0;
      b_addr              <= '0;
      dst_addr            <= '0;
      op                  <= 1'b0;
      len                 <= '0;
      k                   <= '0;
      a_reg               <= '0;
      out_address         <= '0;
      out_data            <= '0;
      out_read_en         <= 1'b0;
      out_write_en        <= 1'b0;
      out_status          <= '0;
      out_write_status_en <= 1'b0;
    end else begin
      out_read_en         <= 1'b0;
      out_write_en        <= 1'b0;
      out_write_status_en <= 1'b0;
      out_data            <= '0;
      case (state)
        IDLE: begin
          if (in_config[CFG_START] && !in_status[ST_DONE]) begin
            a_addr              <= in_config[CFG_A_LSB +: log_size];
            b_addr              <= in_config[CFG_B_LSB +: log_size];
            dst_addr            <= in_config[CFG_DST_LSB +: log_size];
            op                  <= in_config[CFG_OP];
            k                   <= '0;
            len                 <= '0;
            out_read_en         <= 1'b1;
            out_address         <= '0;
            out_status          <= status_out(1'b1, 1'b0, 1'b0, '0);
            out_write_status_en <= 1'b1;
            state               <= DESC_REQ;
          end
        end
        DESC_REQ: state <= DESC_CAP;
        DESC_CAP: begin
          len <= desc_len;
          if (desc_error) begin
            out_status          <= status_out(1'b0, 1'b1, 1'b1, '0);
            out_write_status_en <= 1'b1;
            state               <= DONE;
          end else if (desc_len == '0) begin
            out_status          <= status_out(1'b0, 1'b1, 1'b0, '0);
            out_write_status_en <= 1'b1;
            state               <= DONE;
          end else begin
            out_read_en <= 1'b1;
            out_address <= a_addr;
            state       <= RD_A;
          end
        end
        RD_A: begin
          out_read_en <= 1'b1;
          out_address <= b_addr;
          state       <= RD_B;
        end
        RD_B: begin
          a_reg <= in_data;
          state <= EXE;
        end
        EXE: begin
          out_data            <= alu_result;
          out_write_en        <= 1'b1;
          out_address         <= dst_addr;
          out_status          <= status_out(1'b1, 1'b0, 1'b0, k + LEN_W'(1));
          out_write_status_en <= 1'b1;
          state               <= WR;
        end
        WR: begin
          k        <= k + LEN_W'(1);
          a_addr   <= a_addr + STRIDE;
          b_addr   <= b_addr + STRIDE;
          dst_addr <= dst_addr + STRIDE;
          if (k + LEN_W'(1) < len) begin
            out_read_en <= 1'b1;
            out_address <= a_addr + STRIDE;
            state       <= RD_A;
          end else begin
            out_status          <= status_out(1'b0, 1'b1, 1'b0, len);
            out_write_status_en <= 1'b1;
            state               <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_engine.sv
// Bench for vector_engine: behavioural memory plus a per-cycle expected-output trace.
module tb_vector_engine;

  localparam int SIZE = 1024;
  localparam int BLK  = 4;
  localparam int LOG  = 10;
  localparam int CW   = 32;
  localparam int W    = BLK * CW;

  typedef struct {
    logic           rd;
    logic           wr;
    logic           wst;
    logic [LOG-1:0] addr;
    logic [W-1:0]   data;
    logic [CW-1:0]  status;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [CW-1:0]  mem [SIZE] = '{default: '0};
  logic [W-1:0]   rdata = '0;
  logic           host_we = 1'b0;
  logic [LOG-1:0] host_addr = '0;
  logic [CW-1:0]  host_wdata = '0;

  logic [LOG-1:0] address;
  logic [W-1:0]   data_out;
  logic           read_en;
  logic           write_en;
  logic [CW-1:0]  status;
  logic           status_en;

  int   total = 0;
  int   bad = 0;
  int   runs_started = 0;
  int   runs_done = 0;
  int   rd_seen = 0;
  int   wr_seen = 0;
  int   last_trace_len = 0;
  bit   armed = 1'b0;
  bit   was_idle;
  exp_t cur;
  exp_t trace[$];

  always #5 clk = ~clk;

  vector_engine #(
    .size       (SIZE),
    .blocks     (BLK),
    .log_size   (LOG),
    .cell_width (CW),
    .width      (W)
  ) dut (
    .in_clk              (clk),
    .in_reset            (reset),
    .in_config           (mem[0]),
    .in_status           (mem[1]),
    .in_data             (rdata),
    .out_address         (address),
    .out_data            (data_out),
    .out_read_en         (read_en),
    .out_write_en        (write_en),
    .out_status          (status),
    .out_write_status_en (status_en)
  );

  // Synchronous memory: read data next cycle, garbage when no read was issued
  always @(posedge clk) begin
    if (read_en) begin
      for (int i = 0; i < BLK; i++) rdata[i*CW +: CW] <= mem[address + LOG'(i)];
    end else begin
      rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    if (write_en) begin
      for (int i = 0; i < BLK; i++) mem[address + LOG'(i)] <= data_out[i*CW +: CW];
    end
    if (status_en) mem[1] <= status;
    if (host_we) mem[host_addr] <= host_wdata;
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] statusWord(input bit busy, input bit done, input bit err, input int count);
    return 32'(busy) | (32'(done) << 1) | (32'(err) << 2) | (32'(count) << 16);
  endfunction

  function automatic logic [31:0] cfgWord(input bit start, input int a, input int b, input int d, input bit op);
    return {op, 10'(d), 10'(b), 10'(a), start};
  endfunction

  function automatic exp_t mk(input bit rd, input bit wr, input bit wst, input int addr,
                              input logic [W-1:0] data, input logic [CW-1:0] st);
    exp_t e;
    e.rd = rd; e.wr = wr; e.wst = wst; e.addr = LOG'(addr); e.data = data; e.status = st;
    return e;
  endfunction

  // Whole-run expectation computed from a snapshot of memory at start detect
  function automatic void buildTrace();
    logic [CW-1:0] mm [SIZE];
    logic [CW-1:0] cfg, av, bv;
    logic [W-1:0]  res;
    int a, b, d, len;
    bit op, err;
    mm  = mem;
    cfg = mm[0];
    a   = int'(cfg[10:1]);
    b   = int'(cfg[20:11]);
    d   = int'(cfg[30:21]);
    op  = cfg[31];
    len = int'(mm[2][15:0]);
    err = (a + 4*len > SIZE) || (b + 4*len > SIZE) || (d + 4*len > SIZE) || (d < 2);
    trace.push_back(mk(1, 0, 1, 0, '0, statusWord(1, 0, 0, 0)));
    mm[1] = statusWord(1, 0, 0, 0);
    trace.push_back(mk(0, 0, 0, 0, '0, '0));
    if (err) begin
      trace.push_back(mk(0, 0, 1, 0, '0, statusWord(0, 1, 1, 0)));
    end else if (len == 0) begin
      trace.push_back(mk(0, 0, 1, 0, '0, statusWord(0, 1, 0, 0)));
    end else begin
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < BLK; i++) begin
          av = mm[(a + 4*k + i) % SIZE];
          bv = mm[(b + 4*k + i) % SIZE];
          res[i*CW +: CW] = op ? av - bv : av + bv;
        end
        trace.push_back(mk(1, 0, 0, a + 4*k, '0, '0));
        trace.push_back(mk(1, 0, 0, b + 4*k, '0, '0));
        trace.push_back(mk(0, 0, 0, 0, '0, '0));
        trace.push_back(mk(0, 1, 1, d + 4*k, res, statusWord(1, 0, 0, k + 1)));
        for (int i = 0; i < BLK; i++) mm[(d + 4*k + i) % SIZE] = res[i*CW +: CW];
        mm[1] = statusWord(1, 0, 0, k + 1);
      end
      trace.push_back(mk(0, 0, 1, 0, '0, statusWord(0, 1, 0, len)));
    end
    last_trace_len = trace.size();
  endfunction

  // Per-cycle comparison of DUT outputs against the expected trace
  always @(negedge clk) begin
    if (armed) begin
      if (read_en) rd_seen++;
      if (write_en) wr_seen++;
      checkOutput("rd_wr_exclusive", W'(read_en & write_en), '0);
      if (trace.size() != 0) begin
        was_idle = 1'b0;
        cur = trace.pop_front();
        checkOutput("read_en", W'(read_en), W'(cur.rd));
        checkOutput("write_en", W'(write_en), W'(cur.wr));
        checkOutput("status_en", W'(status_en), W'(cur.wst));
        checkOutput("data", data_out, cur.data);
        if (cur.rd || cur.wr) checkOutput("address", W'(address), W'(cur.addr));
        if (cur.wst) checkOutput("status", W'(status), W'(cur.status));
        if (trace.size() == 0) runs_done++;
      end else begin
        was_idle = 1'b1;
        checkOutput("idle_strobes", W'({read_en, write_en, status_en}), '0);
        checkOutput("idle_data", data_out, '0);
      end
      if (reset) begin
        trace.delete();
      end else if (was_idle && mem[0][0] && !mem[1][1]) begin
        buildTrace();
        runs_started++;
      end
    end
  end

  task automatic applyStimulus(input int addr, input logic [CW-1:0] value);
    @(posedge clk);
    #1;
    host_we    = 1'b1;
    host_addr  = LOG'(addr);
    host_wdata = value;
    @(posedge clk);
    #1;
    host_we = 1'b0;
  endtask

  task automatic prepRun(input int len);
    logic [15:0] upper;
    upper = 16'($urandom());
    applyStimulus(0, '0);
    applyStimulus(1, '0);
    applyStimulus(2, {upper, 16'(len)});
  endtask

  task automatic waitRun(input int budget);
    int start;
    int n;
    start = runs_done;
    n = 0;
    while (runs_done == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (runs_done == start) begin
      total++;
      bad++;
      $display("[TB] FAIL run_timeout: got no completion within %0d cycles", budget);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rd0, wr0, rs0;
    int len, mode, a, b, d, maxb;
    bit op;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_address", W'(address), '0);
    checkOutput("reset_status", W'(status), '0);
    checkOutput("reset_strobes", W'({read_en, write_en, status_en}), '0);
    checkOutput("reset_data", data_out, '0);
    armed = 1'b1;

    // Basic add run: two blocks
    $display("[TB] add len=2");
    prepRun(2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16 + i, 32'(i + 1));
      applyStimulus(32 + i, 32'(10 * (i + 1)));
    end
    applyStimulus(0, cfgWord(1, 16, 32, 48, 0));
    waitRun(200);
    checkOutput("t1_trace_len", W'(last_trace_len), W'(11));
    checkOutput("t1_status", W'(mem[1]), W'(32'h0002_0002));
    for (int i = 0; i < 8; i++) checkOutput("t1_cell", W'(mem[48 + i]), W'(11 * (i + 1)));

    // Start held after done must not retrigger; clearing status rearms
    $display("[TB] start held, then rearm");
    rd0 = rd_seen;
    rs0 = runs_started;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6_no_reads", W'(rd_seen - rd0), '0);
    checkOutput("t6_no_restart", W'(runs_started - rs0), '0);
    applyStimulus(1, '0);
    waitRun(200);
    checkOutput("t6_rerun_reads", W'(rd_seen - rd0), W'(5));
    checkOutput("t6_status", W'(mem[1]), W'(32'h0002_0002));

    // Subtract with borrow per lane only
    $display("[TB] sub wrap");
    prepRun(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(100 + i, 32'd0);
      applyStimulus(200 + i, 32'd1);
    end
    applyStimulus(0, cfgWord(1, 100, 200, 300, 1));
    waitRun(200);
    for (int i = 0; i < 4; i++) checkOutput("t2_cell", W'(mem[300 + i]), W'(32'hFFFF_FFFF));
    checkOutput("t2_status", W'(mem[1]), W'(32'h0001_0002));

    // Error: dst_base below 2
    $display("[TB] error dst=0");
    wr0 = wr_seen;
    prepRun(2);
    applyStimulus(0, cfgWord(1, 16, 32, 0, 0));
    waitRun(200);
    checkOutput("t3a_status", W'(mem[1]), W'(32'h0000_0006));
    checkOutput("t3a_no_writes", W'(wr_seen - wr0), '0);
    checkOutput("t3a_trace_len", W'(last_trace_len), W'(3));

    // Error: A range ends at 1028
    $display("[TB] error a overflow");
    wr0 = wr_seen;
    prepRun(2);
    applyStimulus(0, cfgWord(1, 1020, 32, 48, 0));
    waitRun(200);
    checkOutput("t3b_status", W'(mem[1]), W'(32'h0000_0006));
    checkOutput("t3b_no_writes", W'(wr_seen - wr0), '0);

    // Zero-length descriptor
    $display("[TB] len=0");
    rd0 = rd_seen;
    wr0 = wr_seen;
    prepRun(0);
    applyStimulus(0, cfgWord(1, 16, 32, 48, 0));
    waitRun(200);
    checkOutput("t4_status", W'(mem[1]), W'(32'h0000_0002));
    checkOutput("t4_trace_len", W'(last_trace_len), W'(3));
    checkOutput("t4_reads", W'(rd_seen - rd0), W'(1));
    checkOutput("t4_writes", W'(wr_seen - wr0), '0);

    // Reset in the middle of block 1, start still set
    $display("[TB] reset mid-run");
    prepRun(3);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(400 + i, 32'(i));
      applyStimulus(500 + i, 32'(256 + i));
    end
    applyStimulus(0, cfgWord(1, 400, 500, 600, 0));
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    waitRun(200);
    checkOutput("t5_status", W'(mem[1]), W'(32'h0003_0002));
    checkOutput("t5_cell_first", W'(mem[600]), W'(32'h100));
    checkOutput("t5_cell_last", W'(mem[611]), W'(32'h116));

    // Randomized runs, including overlap and error descriptors
    $display("[TB] random runs");
    for (int r = 0; r < 25; r++) begin
      len  = $urandom_range(6, 0);
      mode = $urandom_range(9, 0);
      op   = 1'($urandom_range(1, 0));
      maxb = SIZE - 4 * len;
      a = $urandom_range(maxb, 0);
      b = $urandom_range(maxb, 0);
      d = $urandom_range(maxb, 2);
      if (mode == 0) d = $urandom_range(1, 0);
      else if (mode == 1 && len > 0) a = $urandom_range(1023, maxb + 1);
      else if (mode == 2) d = (a < 2) ? 2 : a;
      prepRun(len);
      for (int i = 0; i < 4 * len; i++) begin
        if ((a + i) % SIZE >= 3) applyStimulus((a + i) % SIZE, $urandom());
        if ((b + i) % SIZE >= 3) applyStimulus((b + i) % SIZE, $urandom());
      end
      applyStimulus(0, cfgWord(1, a, b, d, op));
      waitRun(200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
